// File: rtl/noc_network_interface_pkg.sv
// Register map and bit positions shared by the NoC network interface.
// Offsets are byte offsets within the 32-byte register window.
package noc_network_interface_pkg;

  localparam logic [4:0] OFF_TX_ADDR = 5'h00;
  localparam logic [4:0] OFF_TX_DATA = 5'h04;
  localparam logic [4:0] OFF_RX_ADDR = 5'h08;
  localparam logic [4:0] OFF_RX_DATA = 5'h0C;
  localparam logic [4:0] OFF_STATUS  = 5'h10;
  localparam logic [4:0] OFF_IRQ_EN  = 5'h14;
  localparam logic [4:0] OFF_CTRL    = 5'h18;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;
  localparam int ST_RX_THR   = 6;

  localparam int IE_RX_AVAIL = 0;
  localparam int IE_RX_THR   = 1;
  localparam int IE_TX_EMPTY = 2;
  localparam int IE_ERR      = 3;

endpackage

// File: rtl/noc_network_interface_sync_fifo.sv
// First-word-fall-through synchronous FIFO (ni_sync_fifo).
// Push/pop legality is the caller's job; this block only tracks state.
module ni_sync_fifo #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 8,
  parameter int THRESH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             threshold
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata     = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign threshold = (count >= CW'(THRESH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_network_interface.sv
// Memory-mapped CPU-to-router network interface with TX/RX flit FIFOs.
// Optional loopback path is built only when NI_LOOPBACK_EN is defined.
module noc_network_interface #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TX_DEPTH  = 8,
  parameter int RX_DEPTH  = 8,
  parameter int RX_THRESH = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  input  logic                   cpu_wr_en,
  input  logic                   cpu_rd_en,
  output logic [ADDR_W+DATA_W-1:0] tx_flit,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [ADDR_W+DATA_W-1:0] rx_flit,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   irq
);
  import noc_network_interface_pkg::*;

  localparam int FW  = ADDR_W + DATA_W;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic            hit;
  logic [4:0]      off;
  logic            sel_tx_addr, sel_tx_data, sel_rx_addr;
  logic            sel_rx_data, sel_status, sel_irq_en;

  logic            tx_full, tx_empty, tx_push, tx_pop;
  logic            tx_wr, tx_out_pop, tx_thresh_unused;
  logic [TCW-1:0]  tx_count;
  logic [FW-1:0]   tx_head;

  logic            rx_full, rx_empty, rx_push, rx_pop;
  logic            rx_rd, rx_in, rx_thresh;
  logic [RCW-1:0]  rx_count;
  logic [FW-1:0]   rx_head, rx_wdata;

  logic [ADDR_W-1:0] staged_addr;
  logic [3:0]      irq_en;
  logic            tx_overflow, rx_underflow;
  logic            ready_q;
  logic            loopback, lb_move;
  logic [31:0]     status_word;
  logic [DATA_W-1:0] rd_next;

  assign hit = (cpu_addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
  assign off = cpu_addr[4:0];

  assign sel_tx_addr = hit & (off == OFF_TX_ADDR);
  assign sel_tx_data = hit & (off == OFF_TX_DATA);
  assign sel_rx_addr = hit & (off == OFF_RX_ADDR);
  assign sel_rx_data = hit & (off == OFF_RX_DATA);
  assign sel_status  = hit & (off == OFF_STATUS);
  assign sel_irq_en  = hit & (off == OFF_IRQ_EN);

`ifdef NI_LOOPBACK_EN
  logic sel_ctrl;
  assign sel_ctrl = hit & (off == OFF_CTRL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) loopback <= 1'b0;
    else if (cpu_wr_en & sel_ctrl) loopback <= cpu_wdata[0];
  end

  // A move is one atomic pop+push, so toggling loopback never splits a flit.
  assign lb_move = loopback & !tx_empty & !rx_full;
`else
  assign loopback = 1'b0;
  assign lb_move  = 1'b0;
`endif

  assign tx_valid   = !tx_empty & !loopback;
  assign tx_flit    = tx_head;
  assign tx_out_pop = tx_valid & tx_ready;
  assign tx_pop     = tx_out_pop | lb_move;
  assign tx_wr      = cpu_wr_en & sel_tx_data;
  assign tx_push    = tx_wr & (!tx_full | tx_pop);

  assign rx_ready = ready_q & !rx_full & !loopback;
  assign rx_in    = rx_valid & rx_ready;
  assign rx_push  = rx_in | lb_move;
  assign rx_wdata = lb_move ? tx_head : rx_flit;
  assign rx_rd    = cpu_rd_en & sel_rx_data;
  assign rx_pop   = rx_rd & !rx_empty;

  ni_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (TX_DEPTH),
    .THRESH(TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_push),
    .pop      (tx_pop),
    .wdata    ({staged_addr, cpu_wdata}),
    .rdata    (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count),
    .threshold(tx_thresh_unused)
  );

  ni_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (RX_DEPTH),
    .THRESH(RX_THRESH)
  ) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .pop      (rx_pop),
    .wdata    (rx_wdata),
    .rdata    (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count),
    .threshold(rx_thresh)
  );

  always_comb begin
    status_word = '0;
    status_word[ST_TX_FULL]  = tx_full;
    status_word[ST_TX_EMPTY] = tx_empty;
    status_word[ST_RX_FULL]  = rx_full;
    status_word[ST_RX_EMPTY] = rx_empty;
    status_word[ST_TX_OVF]   = tx_overflow;
    status_word[ST_RX_UDF]   = rx_underflow;
    status_word[ST_RX_THR]   = rx_thresh;
    status_word[15:8]        = 8'(tx_count);
    status_word[23:16]       = 8'(rx_count);
  end

  always_comb begin
    rd_next = '0;
    unique case (1'b1)
      sel_tx_addr: rd_next = DATA_W'(staged_addr);
      sel_rx_addr: rd_next = rx_empty ? '0 : DATA_W'(rx_head[FW-1:DATA_W]);
      sel_rx_data: rd_next = rx_empty ? '0 : rx_head[DATA_W-1:0];
      sel_status:  rd_next = DATA_W'(status_word);
      sel_irq_en:  rd_next = DATA_W'(irq_en);
`ifdef NI_LOOPBACK_EN
      sel_ctrl:    rd_next = DATA_W'(loopback);
`endif
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata    <= '0;
      staged_addr  <= '0;
      irq_en       <= '0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      ready_q      <= 1'b0;
      irq          <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (cpu_rd_en) cpu_rdata <= rd_next;
      if (cpu_wr_en & sel_tx_addr) staged_addr <= ADDR_W'(cpu_wdata);
      if (cpu_wr_en & sel_irq_en) irq_en <= cpu_wdata[3:0];
      if (cpu_wr_en & sel_status) begin
        if (cpu_wdata[ST_TX_OVF]) tx_overflow  <= 1'b0;
        if (cpu_wdata[ST_RX_UDF]) rx_underflow <= 1'b0;
      end
      // A new error in the same cycle as its W1C wins.
      if (tx_wr & !tx_push) tx_overflow  <= 1'b1;
      if (rx_rd & rx_empty) rx_underflow <= 1'b1;
      irq <= (irq_en[IE_RX_AVAIL] & !rx_empty)
           | (irq_en[IE_RX_THR]   & rx_thresh)
           | (irq_en[IE_TX_EMPTY] & tx_empty)
           | (irq_en[IE_ERR]      & (tx_overflow | rx_underflow));
    end
  end

endmodule

// File: tb/tb_noc_network_interface.sv
// Directed self-checking bench for noc_network_interface.
// Default build (NI_LOOPBACK_EN undefined), default parameters.
module tb_noc_network_interface;

  localparam logic [31:0] BASE      = 32'hFFFF_FF00;
  localparam logic [31:0] A_TX_ADDR = BASE + 32'h00;
  localparam logic [31:0] A_TX_DATA = BASE + 32'h04;
  localparam logic [31:0] A_RX_ADDR = BASE + 32'h08;
  localparam logic [31:0] A_RX_DATA = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS  = BASE + 32'h10;
  localparam logic [31:0] A_IRQ_EN  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_wr_en = 1'b0;
  logic        cpu_rd_en = 1'b0;
  logic [63:0] tx_flit;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [63:0] rx_flit = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        irq;

  int          n_checks = 0;
  int          n_errs = 0;
  logic [31:0] rd;
  logic [31:0] exp_q [$];
  logic [31:0] tx_exp [8];

  noc_network_interface dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_wr_en(cpu_wr_en),
    .cpu_rd_en(cpu_rd_en),
    .tx_flit  (tx_flit),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_flit  (rx_flit),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_wr_en = 1'b1;
    @(negedge clk);
    cpu_wr_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_rd_en = 1'b1;
    @(negedge clk);
    cpu_rd_en = 1'b0;
    d = cpu_rdata;
  endtask

  task automatic rx_send(input logic [31:0] src, input logic [31:0] pl);
    @(negedge clk);
    rx_flit = {src, pl}; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_rdata", 64'(cpu_rdata), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rx_ready_rel", 64'(rx_ready), 64'd1);
    cpu_read(A_STATUS, rd);
    check("status_idle", 64'(rd), 64'h0A);

    // Basic TX
    cpu_write(A_TX_ADDR, 32'h12);
    cpu_read(A_TX_ADDR, rd);
    check("tx_addr_rb", 64'(rd), 64'h12);
    cpu_write(A_TX_DATA, 32'hDEAD_BEEF);
    check("tx_valid_1", 64'(tx_valid), 64'd1);
    check("tx_flit_1", tx_flit, 64'h0000_0012_DEAD_BEEF);
    cpu_read(A_STATUS, rd);
    check("status_tx1", 64'(rd), 64'h108);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("tx_popped", 64'(tx_valid), 64'd0);

    // TX full and overflow
    cpu_write(A_TX_ADDR, 32'h34);
    for (int i = 0; i < 9; i++) cpu_write(A_TX_DATA, 32'(i));
    cpu_read(A_STATUS, rd);
    check("status_txfull", 64'(rd), 64'h819);
    check("tx_head_full", tx_flit, 64'h0000_0034_0000_0000);
    cpu_write(A_STATUS, 32'h10);
    cpu_read(A_STATUS, rd);
    check("status_w1c", 64'(rd), 64'h809);

    // Full plus simultaneous pop: push accepted
    @(negedge clk);
    cpu_addr = A_TX_DATA; cpu_wdata = 32'hAA;
    cpu_wr_en = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    cpu_wr_en = 1'b0; tx_ready = 1'b0;
    cpu_read(A_STATUS, rd);
    check("status_fullpop", 64'(rd), 64'h809);
    for (int i = 0; i < 7; i++) tx_exp[i] = 32'(i + 1);
    tx_exp[7] = 32'hAA;
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tx_drain", tx_flit, {32'h34, tx_exp[i]});
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check("tx_drained", 64'(tx_valid), 64'd0);

    // RX threshold interrupt
    cpu_write(A_IRQ_EN, 32'h2);
    for (int i = 0; i < 4; i++) begin
      rx_send(32'h100 + 32'(i), 32'hA000_0000 + 32'(i));
      exp_q.push_back(32'hA000_0000 + 32'(i));
    end
    check("irq_lat", 64'(irq), 64'd0);
    @(negedge clk);
    check("irq_thr", 64'(irq), 64'd1);
    cpu_read(A_RX_ADDR, rd);
    check("rx_addr_peek", 64'(rd), 64'h100);
    cpu_read(A_RX_DATA, rd);
    check("rx_data_0", 64'(rd), 64'(exp_q.pop_front()));
    @(negedge clk);
    check("irq_clr", 64'(irq), 64'd0);
    cpu_write(A_IRQ_EN, 32'h0);

    // RX order across pointer wrap, push and pop in the same cycle
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rx_flit = {32'h200 + 32'(k), 32'hB000_0000 + 32'(k)};
      rx_valid = 1'b1;
      cpu_addr = A_RX_DATA; cpu_rd_en = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0; cpu_rd_en = 1'b0;
      check("rx_order", 64'(cpu_rdata), 64'(exp_q.pop_front()));
      exp_q.push_back(32'hB000_0000 + 32'(k));
    end
    for (int i = 0; i < 3; i++) begin
      cpu_read(A_RX_DATA, rd);
      check("rx_tail", 64'(rd), 64'(exp_q.pop_front()));
    end
    cpu_read(A_RX_DATA, rd);
    check("rx_empty_rd", 64'(rd), 64'd0);
    cpu_read(A_STATUS, rd);
    check("status_udf", 64'(rd), 64'h2A);
    cpu_write(A_STATUS, 32'h20);
    cpu_read(A_STATUS, rd);
    check("status_udf_clr", 64'(rd), 64'h0A);

    // Decode miss
    cpu_write(32'h0000_0004, 32'h55);
    check("miss_wr", 64'(tx_valid), 64'd0);
    cpu_read(32'h0000_0010, rd);
    check("miss_rd", 64'(rd), 64'd0);

    // RX full
    for (int i = 0; i < 8; i++) rx_send(32'h300, 32'(i));
    check("rx_full_rdy", 64'(rx_ready), 64'd0);
    cpu_read(A_STATUS, rd);
    check("status_rxfull", 64'(rd), 64'h0008_0046);

    // Async reset mid-handshake with TX queued
    for (int i = 0; i < 3; i++) cpu_write(A_TX_DATA, 32'(i));
    cpu_write(A_IRQ_EN, 32'h1);
    @(negedge clk);
    check("pre_rst_irq", 64'(irq), 64'd1);
    check("pre_rst_txv", 64'(tx_valid), 64'd1);
    tx_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("arst_txv", 64'(tx_valid), 64'd0);
    check("arst_irq", 64'(irq), 64'd0);
    check("arst_rxrdy", 64'(rx_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    check("arst_rxrdy_rel", 64'(rx_ready), 64'd1);
    cpu_read(A_STATUS, rd);
    check("arst_status", 64'(rd), 64'h0A);
    cpu_read(A_IRQ_EN, rd);
    check("arst_irq_en", 64'(rd), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
